// File: rtl/mem_lite2full_bridge_if.sv
// Bus bundle between a lite core port and split instruction/data SRAM-style channels.
// Handshakes: lite side holds lite_valid_i until the one-cycle lite_ready_o pulse;
// mem side holds *_req_o and its fields stable until sampled with *_gnt_i=1, and the
// response arrives as a one-cycle *_valid_i (with *_error_i) at or after the grant.
interface mem_lite2full_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB = DATA_WIDTH / 8;

  logic                  lite_valid_i;
  logic                  lite_instr_i;
  logic [ADDR_WIDTH-1:0] lite_addr_i;
  logic [DATA_WIDTH-1:0] lite_wdata_i;
  logic [STRB-1:0]       lite_wstrb_i;
  logic                  lite_ready_o;
  logic [DATA_WIDTH-1:0] lite_rdata_o;
  logic                  lite_err_o;

  logic                  mem_instr_req_o;
  logic                  mem_instr_gnt_i;
  logic                  mem_instr_valid_i;
  logic                  mem_instr_error_i;
  logic [ADDR_WIDTH-1:0] mem_instr_addr_o;
  logic [DATA_WIDTH-1:0] mem_instr_rdata_i;

  logic                  mem_data_req_o;
  logic                  mem_data_gnt_i;
  logic                  mem_data_valid_i;
  logic                  mem_data_error_i;
  logic [ADDR_WIDTH-1:0] mem_data_addr_o;
  logic [DATA_WIDTH-1:0] mem_data_wdata_o;
  logic [STRB-1:0]       mem_data_be_o;
  logic                  mem_data_we_o;
  logic [DATA_WIDTH-1:0] mem_data_rdata_i;

  // Bridge view.
  modport master (
    input  lite_valid_i, lite_instr_i, lite_addr_i, lite_wdata_i, lite_wstrb_i,
    output lite_ready_o, lite_rdata_o, lite_err_o,
    output mem_instr_req_o, mem_instr_addr_o,
    input  mem_instr_gnt_i, mem_instr_valid_i, mem_instr_error_i, mem_instr_rdata_i,
    output mem_data_req_o, mem_data_addr_o, mem_data_wdata_o, mem_data_be_o, mem_data_we_o,
    input  mem_data_gnt_i, mem_data_valid_i, mem_data_error_i, mem_data_rdata_i
  );

  // Environment view (core plus memories).
  modport slave (
    output lite_valid_i, lite_instr_i, lite_addr_i, lite_wdata_i, lite_wstrb_i,
    input  lite_ready_o, lite_rdata_o, lite_err_o,
    input  mem_instr_req_o, mem_instr_addr_o,
    output mem_instr_gnt_i, mem_instr_valid_i, mem_instr_error_i, mem_instr_rdata_i,
    input  mem_data_req_o, mem_data_addr_o, mem_data_wdata_o, mem_data_be_o, mem_data_we_o,
    output mem_data_gnt_i, mem_data_valid_i, mem_data_error_i, mem_data_rdata_i
  );
endinterface

// File: rtl/mem_lite2full_bridge.sv
// Lite core port to split instr/data req/gnt/valid channels: holds the request until
// granted, tracks the single outstanding response, reports errors and optional timeouts.
module mem_lite2full_bridge #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    TIMEOUT_CYCLES = 0,
  parameter logic [31:0]           ERR_INSTR      = 32'h0010_0073,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA      = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  mem_lite2full_bridge_if.master bus,
  input  logic                   err_clr_i,
  output logic                   err_sticky_o,
  output logic [ADDR_WIDTH-1:0]  err_addr_o,
  output logic [1:0]             state_o
);
  localparam int STRB  = DATA_WIDTH / 8;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [DATA_WIDTH-1:0] ERR_INSTR_X = DATA_WIDTH'(ERR_INSTR);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]            state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB-1:0]       wstrb_q;
  logic                  instr_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  drop_instr_q;
  logic                  drop_data_q;
  logic                  err_sticky_q;
  logic [ADDR_WIDTH-1:0] err_addr_q;

  logic                  sel_gnt, sel_valid, sel_error, sel_drop, is_write;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  present, granted, resp_now, timeout_now, resp_err;
  logic [DATA_WIDTH-1:0] resp_data;

  // Only the selected channel's inputs take part in the handshake.
  always_comb begin
    sel_gnt   = instr_q ? bus.mem_instr_gnt_i   : bus.mem_data_gnt_i;
    sel_valid = instr_q ? bus.mem_instr_valid_i : bus.mem_data_valid_i;
    sel_error = instr_q ? bus.mem_instr_error_i : bus.mem_data_error_i;
    sel_rdata = instr_q ? bus.mem_instr_rdata_i : bus.mem_data_rdata_i;
    sel_drop  = instr_q ? drop_instr_q          : drop_data_q;
    is_write  = !instr_q && (|wstrb_q);
    // A request is not presented while a timed-out response is still owed on that channel.
    present     = (state_q == S_REQ) && !sel_drop;
    granted     = present && sel_gnt;
    timeout_now = (TIMEOUT_CYCLES != 0) && (state_q == S_WAIT) && !sel_valid && (cnt_q == CNT_LAST);
    resp_now    = (granted && sel_valid) || ((state_q == S_WAIT) && sel_valid) || timeout_now;
    resp_err    = timeout_now || sel_error;
    if (is_write)     resp_data = '0;
    else if (resp_err) resp_data = instr_q ? ERR_INSTR_X : ERR_RDATA;
    else              resp_data = sel_rdata;
  end

  always_comb begin
    bus.mem_instr_req_o  = present && instr_q;
    bus.mem_instr_addr_o = (present && instr_q) ? addr_q : '0;
    bus.mem_data_req_o   = present && !instr_q;
    bus.mem_data_addr_o  = (present && !instr_q) ? addr_q : '0;
    bus.mem_data_wdata_o = (present && !instr_q) ? wdata_q : '0;
    bus.mem_data_be_o    = (present && !instr_q) ? wstrb_q : '0;
    bus.mem_data_we_o    = present && !instr_q && (|wstrb_q);
    bus.lite_ready_o     = (state_q == S_RESP);
    bus.lite_rdata_o     = (state_q == S_RESP) ? rdata_q : '0;
    bus.lite_err_o       = (state_q == S_RESP) && err_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      instr_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.lite_valid_i) begin
          addr_q  <= bus.lite_addr_i;
          wdata_q <= bus.lite_wdata_i;
          wstrb_q <= bus.lite_wstrb_i;
          instr_q <= bus.lite_instr_i;
          state_q <= S_REQ;
        end
        S_REQ: if (granted) begin
          cnt_q   <= '0;
          state_q <= sel_valid ? S_RESP : S_WAIT;
        end
        S_WAIT: if (!resp_now && cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
                else if (resp_now) state_q <= S_RESP;
        default: state_q <= S_IDLE;
      endcase
      if (resp_now) begin
        rdata_q <= resp_data;
        err_q   <= resp_err;
      end
    end
  end

  // A late response for a timed-out request is swallowed by its drop flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drop_instr_q <= 1'b0;
      drop_data_q  <= 1'b0;
    end else begin
      if (timeout_now && instr_q)                  drop_instr_q <= 1'b1;
      else if (drop_instr_q && bus.mem_instr_valid_i) drop_instr_q <= 1'b0;
      if (timeout_now && !instr_q)                 drop_data_q <= 1'b1;
      else if (drop_data_q && bus.mem_data_valid_i)  drop_data_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_sticky_q <= 1'b0;
      err_addr_q   <= '0;
    end else begin
      if (err_clr_i)                        err_sticky_q <= 1'b0;
      else if (state_q == S_RESP && err_q)  err_sticky_q <= 1'b1;
      if (state_q == S_RESP && err_q)       err_addr_q <= addr_q;
    end
  end

  assign err_sticky_o = err_sticky_q;
  assign err_addr_o   = err_addr_q;
  assign state_o      = state_q;
endmodule
